// File: rtl/out_capture_fifo.sv
// rtl/out_capture_fifo.sv - show-ahead capture buffer draining TOP output with sticky overflow flag
module out_capture_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  CLK_I,
  input  logic                  RST_X,
  input  logic [WIDTH-1:0]      DATA_I,
  input  logic                  VALID_I,
  input  logic                  CLEAR_I,
  output logic [WIDTH-1:0]      DATA_O,
  output logic                  VALID_O,
  input  logic                  READY_I,
  output logic [DEPTH_LOG2:0]   LEVEL_O,
  output logic                  FULL_O,
  output logic                  EMPTY_O,
  output logic                  OVERFLOW_O
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LEVEL_MAX = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LEVEL_ONE = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level;
  logic                  overflow;

  logic                  is_full;
  logic                  is_empty;
  logic                  pop;
  logic                  push;
  logic                  drop;

  // Status decodes from the level register only; handshake inputs never reach outputs.
  always_comb begin
    is_full  = (level == LEVEL_MAX);
    is_empty = (level == '0);
    // A pop frees a slot in the same cycle, so a full buffer can still accept a word.
    pop      = !is_empty && READY_I && !CLEAR_I;
    push     = VALID_I && !CLEAR_I && (!is_full || pop);
    drop     = VALID_I && !CLEAR_I && is_full && !pop;
  end

  // Storage array; no reset because stale entries are never visible past the level gate.
  always_ff @(posedge CLK_I) begin
    if (push) begin
      mem[wr_ptr] <= DATA_I;
    end
  end

  // Pointers, level and sticky overflow; clear outranks every other action.
  always_ff @(posedge CLK_I or negedge RST_X) begin
    if (!RST_X) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (CLEAR_I) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   level <= level + LEVEL_ONE;
        2'b01:   level <= level - LEVEL_ONE;
        default: level <= level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Output mapping; data is forced to zero while nothing is stored.
  always_comb begin
    DATA_O     = is_empty ? '0 : mem[rd_ptr];
    VALID_O    = !is_empty;
    EMPTY_O    = is_empty;
    FULL_O     = is_full;
    LEVEL_O    = level;
    OVERFLOW_O = overflow;
  end

endmodule
